// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: two-road intersection controller with latched pedestrian crossing and flashing night mode; ports clk/rst/tick/ped_req/night in, road/walk lamps, ped_wait, phase out
module traffic_ctrl_param #(
  parameter int CW         = 4,
  parameter int T_GA       = 4,
  parameter int T_YA       = 2,
  parameter int T_GB       = 3,
  parameter int T_YB       = 2,
  parameter int T_WALK     = 2,
  parameter int T_FLASH    = 3,
  parameter int BLINK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night,
  output logic       Ra,
  output logic       Ya,
  output logic       Ga,
  output logic       Rb,
  output logic       Yb,
  output logic       Gb,
  output logic       Rw,
  output logic       Gw,
  output logic       ped_wait,
  output logic [2:0] phase
);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [2:0] S_GA = 3'd0, S_YA = 3'd1, S_GB = 3'd2, S_YB = 3'd3,
                         S_WALK = 3'd4, S_FLASH = 3'd5, S_NIGHT = 3'd6;
  logic [2:0]    state_q, state_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d, ped_wait_q, ped_wait_d;
  logic          phase_end, entering, blinking, wrap;

  function automatic logic [CW-1:0] dur(input logic [2:0] s);
    return s == S_GA    ? CW'(T_GA - 1)   :
           s == S_YA    ? CW'(T_YA - 1)   :
           s == S_GB    ? CW'(T_GB - 1)   :
           s == S_YB    ? CW'(T_YB - 1)   :
           s == S_WALK  ? CW'(T_WALK - 1) :
           s == S_FLASH ? CW'(T_FLASH - 1) : '0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_GA;
      cnt_q      <= CW'(T_GA - 1);
      bcnt_q     <= '0;
      blink_q    <= 1'b0;
      ped_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      blink_q    <= blink_d;
      ped_wait_q <= ped_wait_d;
    end
  end

  always_comb begin
    nxt = state_q == S_GA    ? S_YA :
          state_q == S_YA    ? S_GB :
          state_q == S_GB    ? S_YB :
          state_q == S_YB    ? (night ? S_NIGHT : ped_wait_q ? S_WALK : S_GA) :
          state_q == S_WALK  ? S_FLASH :
          state_q == S_FLASH ? (night ? S_NIGHT : S_GA) : S_GA;
    phase_end = state_q == S_NIGHT ? !night : cnt_q == '0;
    state_d   = state_q == 3'd7 ? S_GA : (tick && phase_end) ? nxt : state_q;
    entering  = state_d != state_q;
    cnt_d     = entering ? dur(state_d) : (tick && state_q != S_NIGHT) ? cnt_q - 1'b1 : cnt_q;
    ped_wait_d = (entering && state_d == S_WALK) ? 1'b0 :
                 (ped_req && state_q != S_WALK && state_q != S_FLASH) ? 1'b1 : ped_wait_q;
    blinking = state_d == S_FLASH || state_d == S_NIGHT;
    wrap     = bcnt_q == BW'(BLINK_HALF - 1);
    blink_d  = !blinking ? 1'b0 : entering ? 1'b1 : blink_q ^ wrap;
    bcnt_d   = (!blinking || entering || wrap) ? '0 : bcnt_q + 1'b1;
  end

  always_comb begin
    {Ra, Ya, Ga, Rb, Yb, Gb, Rw, Gw} =
      state_q == S_GA    ? 8'b0011_0010 :
      state_q == S_YA    ? 8'b0101_0010 :
      state_q == S_GB    ? 8'b1000_0110 :
      state_q == S_YB    ? 8'b1000_1010 :
      state_q == S_WALK  ? 8'b1001_0001 :
      state_q == S_FLASH ? {6'b1001_00, blink_q, 1'b0} :
      state_q == S_NIGHT ? {1'b0, blink_q, 2'b00, blink_q, 3'b010} : 8'b1001_0010;
    ped_wait = ped_wait_q;
    phase    = state_q;
  end
endmodule
